// File: rtl/aes_round_sequencer_if.sv
// ---------------------------------------------------------------------------
// aes_round_sequencer_if
//
// Bundles every non-clock/reset signal of the AES round sequencer: the
// start/plaintext/key input side, the req/ack round handshake towards the
// shared single-round datapath, and the status/ciphertext outputs.
//
// Signals:
//   start          begin encryption (honoured only when the sequencer is idle/err)
//   plain_in       128-bit plaintext, MSB = byte 0
//   key_in         128-bit cipher key, MSB = byte 0
//   rnd_req        round request to the datapath
//   rnd_num        current round index 1..NUM_ROUNDS (0 when not requesting)
//   rnd_final      last round marker (datapath skips MixColumns)
//   rnd_state_out  working state handed to the datapath
//   rnd_key_out    previous round key handed to the datapath
//   rnd_ack        datapath result valid, qualifies rnd_state_in/rnd_key_in
//   rnd_state_in   round result state
//   rnd_key_in     next round key
//   busy           sequencer working (not idle, not in error)
//   done           one-cycle completion pulse
//   err            sticky round-ack timeout flag
//   cipher_out     ciphertext, valid from done until the next accepted start
//
// Modports:
//   slave   the sequencer's own view
//   master  the environment's view (host plus round datapath)
// ---------------------------------------------------------------------------
interface aes_round_sequencer_if;
    logic         start;
    logic [127:0] plain_in;
    logic [127:0] key_in;
    logic         rnd_req;
    logic [3:0]   rnd_num;
    logic         rnd_final;
    logic [127:0] rnd_state_out;
    logic [127:0] rnd_key_out;
    logic         rnd_ack;
    logic [127:0] rnd_state_in;
    logic [127:0] rnd_key_in;
    logic         busy;
    logic         done;
    logic         err;
    logic [127:0] cipher_out;

    modport slave (
        input  start, plain_in, key_in, rnd_ack, rnd_state_in, rnd_key_in,
        output rnd_req, rnd_num, rnd_final, rnd_state_out, rnd_key_out,
               busy, done, err, cipher_out
    );

    modport master (
        output start, plain_in, key_in, rnd_ack, rnd_state_in, rnd_key_in,
        input  rnd_req, rnd_num, rnd_final, rnd_state_out, rnd_key_out,
               busy, done, err, cipher_out
    );
endinterface

// File: rtl/aes_round_sequencer.sv
// ---------------------------------------------------------------------------
// aes_round_sequencer
//
// Iterative-round controller for the AES core. On an accepted start it
// captures plaintext and key, performs the initial AddRoundKey itself, then
// hands the working state and round key to a shared single-round datapath
// NUM_ROUNDS times over a req/ack handshake. The final state is presented on
// cipher_out together with a one-cycle done pulse. A per-round ack timeout
// moves the sequencer into a sticky error state that a new start clears.
//
// Parameters:
//   NUM_ROUNDS  rounds issued after the initial AddRoundKey, legal 1..14
//   TIMEOUT     cycles to wait for rnd_ack per round, 0 disables the timeout
//
// Ports:
//   clk   system clock, all state changes on the rising edge
//   rst_  synchronous active-high reset, clears every output and state
//   bus   aes_round_sequencer_if.slave (start, data, round handshake, status)
// ---------------------------------------------------------------------------
module aes_round_sequencer #(
    parameter int NUM_ROUNDS = 10,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst_,
    aes_round_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_ISSUE,
        S_DONE,
        S_ERR
    } seqState_t;

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);
    localparam bit         TO_ENABLE  = (TIMEOUT != 0);
    localparam logic [7:0] TO_LAST    = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

    seqState_t    r_fsm;
    logic [127:0] r_workState;
    logic [127:0] r_roundKey;
    logic [3:0]   r_round;
    logic [7:0]   r_toCnt;

    logic         r_rndReq;
    logic [3:0]   r_rndNum;
    logic         r_rndFinal;
    logic [127:0] r_rndStateOut;
    logic [127:0] r_rndKeyOut;
    logic         r_busy;
    logic         r_done;
    logic         r_err;
    logic [127:0] r_cipher;

    logic [127:0] w_initState;
    logic [3:0]   w_nextRound;
    logic [7:0]   w_toCntSat;
    logic         w_toExpire;

    // Initial AddRoundKey result; it is both the new working state and the
    // first state presented to the datapath.
    assign w_initState = r_workState ^ r_roundKey;
    assign w_nextRound = r_round + 4'd1;

    // The wait counter saturates so a disabled timeout never wraps around.
    assign w_toCntSat = (r_toCnt == 8'hFF) ? r_toCnt : r_toCnt + 8'd1;

    // Expiry is evaluated one count early so err becomes visible exactly
    // TIMEOUT cycles after the round request was first presented.
    assign w_toExpire = TO_ENABLE && (r_toCnt == TO_LAST);

    // Single sequencing FSM. All bus outputs are registers updated on the
    // transition into the state that owns them, so the round handshake
    // outputs are already valid in the first cycle of each round and are
    // zero everywhere outside ISSUE. An ack always beats a coincident
    // timeout because the ack branch is tested first.
    always_ff @(posedge clk) begin
        if (rst_) begin
            r_fsm         <= S_IDLE;
            r_workState   <= '0;
            r_roundKey    <= '0;
            r_round       <= '0;
            r_toCnt       <= '0;
            r_rndReq      <= 1'b0;
            r_rndNum      <= '0;
            r_rndFinal    <= 1'b0;
            r_rndStateOut <= '0;
            r_rndKeyOut   <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_cipher      <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_fsm)
                S_IDLE, S_ERR: begin
                    if (bus.start) begin
                        r_workState <= bus.plain_in;
                        r_roundKey  <= bus.key_in;
                        r_err       <= 1'b0;
                        r_cipher    <= '0;
                        r_busy      <= 1'b1;
                        r_fsm       <= S_INIT;
                    end
                end

                S_INIT: begin
                    r_workState   <= w_initState;
                    r_round       <= 4'd1;
                    r_toCnt       <= '0;
                    r_rndReq      <= 1'b1;
                    r_rndNum      <= 4'd1;
                    r_rndFinal    <= (LAST_ROUND == 4'd1);
                    r_rndStateOut <= w_initState;
                    r_rndKeyOut   <= r_roundKey;
                    r_fsm         <= S_ISSUE;
                end

                S_ISSUE: begin
                    if (bus.rnd_ack) begin
                        r_workState <= bus.rnd_state_in;
                        r_roundKey  <= bus.rnd_key_in;
                        r_toCnt     <= '0;
                        if (r_round == LAST_ROUND) begin
                            r_rndReq      <= 1'b0;
                            r_rndNum      <= '0;
                            r_rndFinal    <= 1'b0;
                            r_rndStateOut <= '0;
                            r_rndKeyOut   <= '0;
                            r_done        <= 1'b1;
                            r_cipher      <= bus.rnd_state_in;
                            r_fsm         <= S_DONE;
                        end else begin
                            // rnd_req stays high so the next round may be
                            // acknowledged in the very next cycle.
                            r_round       <= w_nextRound;
                            r_rndNum      <= w_nextRound;
                            r_rndFinal    <= (w_nextRound == LAST_ROUND);
                            r_rndStateOut <= bus.rnd_state_in;
                            r_rndKeyOut   <= bus.rnd_key_in;
                        end
                    end else begin
                        r_toCnt <= w_toCntSat;
                        if (w_toExpire) begin
                            r_rndReq      <= 1'b0;
                            r_rndNum      <= '0;
                            r_rndFinal    <= 1'b0;
                            r_rndStateOut <= '0;
                            r_rndKeyOut   <= '0;
                            r_busy        <= 1'b0;
                            r_err         <= 1'b1;
                            r_fsm         <= S_ERR;
                        end
                    end
                end

                S_DONE: begin
                    r_busy <= 1'b0;
                    r_fsm  <= S_IDLE;
                end

                default: begin
                    r_fsm <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.rnd_req       = r_rndReq;
    assign bus.rnd_num       = r_rndNum;
    assign bus.rnd_final     = r_rndFinal;
    assign bus.rnd_state_out = r_rndStateOut;
    assign bus.rnd_key_out   = r_rndKeyOut;
    assign bus.busy          = r_busy;
    assign bus.done          = r_done;
    assign bus.err           = r_err;
    assign bus.cipher_out    = r_cipher;

endmodule

// File: doc/aes_round_sequencer.md
# aes_round_sequencer

Iterative-round controller for the AES core. It sits between the input interface (`engine_start`, `plain_out`, `key_out`) and a shared single-round datapath (SubBytes/ShiftRows/MixColumns/AddRoundKey plus one key-schedule step). On start it:
- captures plaintext and key;
- performs the initial AddRoundKey;
- issues NUM_ROUNDS round requests over a req/ack handshake, holding the working state and round key between requests;
- presents the ciphertext with a one-cycle `done` pulse that feeds the input interface's `transformer_done`.

## Interface
Parameters:
- NUM_ROUNDS, 10, rounds issued after the initial AddRoundKey; legal range 1..14.
- TIMEOUT, 255, maximum cycles to wait for `rnd_ack` per round before error; 0 disables the timeout; counter width 8.

Ports (one clock; reset is synchronous and active-high, named `rst_`):
- clk  in  1  system clock; all state changes on rising edge.
- rst_  in  1  synchronous, active-high reset.
- start  in  1  begin encryption; sampled only in IDLE.
- plain_in  in  128  plaintext; captured on the accepted start.
- key_in  in  128  cipher key; captured on the accepted start.
- rnd_req  out  1  round request to the datapath.
- rnd_num  out  4  current round index, 1..NUM_ROUNDS.
- rnd_final  out  1  high when rnd_num == NUM_ROUNDS (datapath skips MixColumns).
- rnd_state_out  out  128  working state sent to the datapath.
- rnd_key_out  out  128  previous round key sent to the datapath.
- rnd_ack  in  1  datapath result valid; qualifies rnd_state_in and rnd_key_in.
- rnd_state_in  in  128  round result state.
- rnd_key_in  in  128  next round key.
- busy  out  1  high in every state except IDLE and ERR.
- done  out  1  one-cycle completion pulse.
- err  out  1  timeout flag; sticky until reset or the next accepted start.
- cipher_out  out  128  ciphertext; valid from the done cycle until the next accepted start.

## Operation
- **Reset values:** rst_ high sets every output to 0, including all 128-bit buses, and forces the state to IDLE. This applies from any state, including mid-round; any rnd_ack arriving in the same cycle is ignored.
- **States:** IDLE, INIT, ISSUE, DONE, ERR.
- **IDLE:**
  - If start=1: latch plain_in into the state register and key_in into the key register, clear err, go to INIT.
  - cipher_out is cleared when start is accepted.
- **INIT (1 cycle):**
  - state_reg <= state_reg ^ key_reg.
  - round <= 1, timeout counter <= 0.
  - Go to ISSUE.
- **ISSUE:**
  - rnd_req=1; rnd_num=round; rnd_state_out=state_reg; rnd_key_out=key_reg.
  - On rnd_ack: state_reg <= rnd_state_in, key_reg <= rnd_key_in, timeout counter <= 0.
    - If round == NUM_ROUNDS, go to DONE.
    - Otherwise round <= round+1 and stay in ISSUE. rnd_req stays high, so back-to-back rounds are legal.
  - Without rnd_ack: increment the timeout counter, saturating at 255. If TIMEOUT≠0 and the counter reaches TIMEOUT-1 with no ack, go to ERR on that edge.
  - rnd_ack and the timeout threshold in the same cycle: the ack wins.
- **DONE (1 cycle):** done=1, cipher_out <= state_reg (visible in this cycle), then go to IDLE.
- **ERR:**
  - err=1, busy=0, rnd_req=0.
  - start=1 behaves as in IDLE: captures inputs, clears err, goes to INIT.
- **Ignored inputs:**
  - start outside IDLE and ERR (no restart mid-operation).
  - rnd_ack outside ISSUE.
- **Gated outputs:** rnd_num, rnd_final, rnd_state_out and rnd_key_out are 0 outside ISSUE.
- **Widths:** round is a 4-bit counter and never wraps, since NUM_ROUNDS ≤ 14. XOR and datapath captures are full 128-bit, MSB = byte 0.

## Timing
- Cycle numbering: the cycle where start=1 in IDLE is cycle 0.
- Cycle 1: INIT. Cycle 2: ISSUE, round 1.
- With rnd_ack held high, round k is presented in cycle k+1 and DONE falls in cycle NUM_ROUNDS+2 (cycle 12 at the default).
- The next start is accepted at the earliest in cycle NUM_ROUNDS+3.
- Each cycle of ack delay in a round adds exactly 1 cycle to total latency.
- rnd_ack may arrive combinationally in the same cycle rnd_req rises. The result is captured on that cycle's rising edge.
- The datapath must hold rnd_state_in and rnd_key_in valid during any cycle with rnd_ack=1.
- Timeout with TIMEOUT=T: if rnd_req rises in cycle c and no ack arrives, err=1 from cycle c+T.

## Test plan
- **FIPS-197 C.1 vector:** plain 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f, bench round model with zero-wait ack -> done=1 exactly in cycle 12, cipher_out=69c4e0d86a7b0430d8cdb78070b4c55a, rnd_final high only on round 10.
- **Random ack stalls:** same vector, 0-5 cycle random delay per round -> identical ciphertext; latency = 12 + total stall cycles; rnd_num steps 1..10 with no skips or repeats.
- **Reset mid-operation:** assert rst_ during round 5 with rnd_ack coinciding -> next cycle all outputs 0, IDLE; a fresh start then produces the correct ciphertext.
- **Timeout:** TIMEOUT=4, never ack round 3 -> err=1 four cycles after round-3 rnd_req rises, busy=0, rnd_req=0; start then clears err and runs to completion.
- **Ignored inputs:** start pulses during ISSUE and DONE, and rnd_ack pulses in IDLE and INIT -> no restart, no state change, done asserted exactly once per accepted start.
- **Back-to-back runs:** start in cycle 13 after a done, same key, new plaintext -> second done in cycle 25; cipher_out cleared in cycle 13 and holds its value between runs.
